// File: rtl/arm_mc_pkg.sv
// Shared encodings for the multicycle ARM control unit: FSM states, datapath
// mux codes, ALU operation codes and condition-code evaluation.
package arm_mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXECR  = 4'd6,
        S_EXECI  = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9
    } state_t;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_EOR = 4'b0001;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_ORR = 3'd3;
    localparam logic [2:0] ALU_EOR = 3'd4;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;

    // Evaluate an ARM condition field against an {N,Z,C,V} flag vector.
    function automatic logic cond_eval(input logic [3:0] cond, input logic [3:0] nzcv);
        logic n, z, c, v, r;
        {n, z, c, v} = nzcv;
        r = 1'b0;
        case (cond)
            COND_EQ: r = z;
            COND_NE: r = ~z;
            COND_CS: r = c;
            COND_CC: r = ~c;
            COND_MI: r = n;
            COND_PL: r = ~n;
            COND_VS: r = v;
            COND_VC: r = ~v;
            COND_HI: r = c & ~z;
            COND_LS: r = ~c | z;
            COND_GE: r = (n == v);
            COND_LT: r = (n != v);
            COND_GT: r = ~z & (n == v);
            COND_LE: r = z | (n != v);
            COND_AL: r = 1'b1;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/arm_cond_logic.sv
// NZCV flag register, condition evaluation and gating of the architectural
// write enables; reset holds every write enable low.
module arm_cond_logic
    import arm_mc_pkg::*;
(
    input  logic       CLK,
    input  logic       RST,
    input  logic [3:0] Cond,
    input  logic [3:0] ALUFlags,
    input  logic [1:0] FlagW,
    input  logic       flag_en,
    input  logic       PCS,
    input  logic       NextPC,
    input  logic       RegW,
    input  logic       MemW,
    input  logic       NoWrite,
    output logic       PCWrite,
    output logic       RegWrite,
    output logic       MemWrite
);

    logic [1:0] nz;
    logic [1:0] cv;
    logic       cond_ex;

    assign cond_ex = cond_eval(Cond, {nz, cv});

    // Flags load only on the edge that leaves an execute state.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            nz <= 2'b00;
            cv <= 2'b00;
        end else if (flag_en && cond_ex) begin
            if (FlagW[1]) nz <= ALUFlags[3:2];
            if (FlagW[0]) cv <= ALUFlags[1:0];
        end
    end

    assign PCWrite  = ~RST & (NextPC | (PCS & cond_ex));
    assign RegWrite = ~RST & RegW & cond_ex & ~NoWrite;
    assign MemWrite = ~RST & MemW & cond_ex;

endmodule

// File: rtl/arm_multicycle_control.sv
// Multicycle ARM control unit: Moore sequencing FSM and ALU decoder, with
// flag handling and conditional write gating in arm_cond_logic.
module arm_multicycle_control
    import arm_mc_pkg::*;
#(
    parameter  int unsigned EXT_OPS   = 0,
    localparam int unsigned ALUCTRL_W = (EXT_OPS != 0) ? 3 : 2
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [3:0]           Cond,
    input  logic [1:0]           Op,
    input  logic [5:0]           Funct,
    input  logic [3:0]           Rd,
    input  logic [3:0]           ALUFlags,
    output logic                 PCWrite,
    output logic                 AdrSrc,
    output logic                 MemWrite,
    output logic                 IRWrite,
    output logic [1:0]           ResultSrc,
    output logic                 ALUSrcA,
    output logic [1:0]           ALUSrcB,
    output logic                 RegWrite,
    output logic [1:0]           ImmSrc,
    output logic [1:0]           RegSrc,
    output logic [ALUCTRL_W-1:0] ALUControl,
    output logic [3:0]           State
);

    state_t     state, state_nxt;
    logic       next_pc, branch, reg_w, mem_w, ir_write, alu_op;
    logic [3:0] cmd;
    logic [2:0] dec_ctrl;
    logic       dec_valid, dec_cv, dec_nowrite;
    logic [1:0] flag_w;
    logic       no_write, pcs, flag_en;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= S_FETCH;
        else     state <= state_nxt;
    end

    // Next state and per-state Moore outputs.
    always_comb begin
        state_nxt = S_FETCH;
        next_pc   = 1'b0;
        branch    = 1'b0;
        reg_w     = 1'b0;
        mem_w     = 1'b0;
        ir_write  = 1'b0;
        alu_op    = 1'b0;
        AdrSrc    = 1'b0;
        ALUSrcA   = 1'b0;
        ALUSrcB   = SRCB_REG;
        ResultSrc = RES_ALUOUT;
        case (state)
            S_FETCH: begin
                state_nxt = S_DECODE;
                ir_write  = 1'b1;
                next_pc   = 1'b1;
                ALUSrcA   = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
            end
            S_DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
                case (Op)
                    OP_MEM:  state_nxt = S_MEMADR;
                    OP_DP:   state_nxt = Funct[5] ? S_EXECI : S_EXECR;
                    OP_BR:   state_nxt = S_BRANCH;
                    default: state_nxt = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                state_nxt = Funct[0] ? S_MEMRD : S_MEMWR;
                ALUSrcB   = SRCB_IMM;
            end
            S_MEMRD: begin
                state_nxt = S_MEMWB;
                AdrSrc    = 1'b1;
            end
            S_MEMWB: begin
                ResultSrc = RES_DATA;
                reg_w     = 1'b1;
            end
            S_MEMWR: begin
                AdrSrc = 1'b1;
                mem_w  = 1'b1;
            end
            S_EXECR: begin
                state_nxt = S_ALUWB;
                alu_op    = 1'b1;
            end
            S_EXECI: begin
                state_nxt = S_ALUWB;
                alu_op    = 1'b1;
                ALUSrcB   = SRCB_IMM;
            end
            S_ALUWB: begin
                reg_w = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcB   = SRCB_IMM;
                ResultSrc = RES_ALURESULT;
                branch    = 1'b1;
            end
            default: state_nxt = S_FETCH;
        endcase
    end

    assign cmd = Funct[4:1];

    // Data-processing command decode; the extended ops exist only with EXT_OPS.
    always_comb begin
        dec_ctrl    = ALU_ADD;
        dec_valid   = 1'b1;
        dec_cv      = 1'b0;
        dec_nowrite = 1'b0;
        case (cmd)
            CMD_ADD: begin dec_ctrl = ALU_ADD; dec_cv = 1'b1; end
            CMD_SUB: begin dec_ctrl = ALU_SUB; dec_cv = 1'b1; end
            CMD_AND: dec_ctrl = ALU_AND;
            CMD_ORR: dec_ctrl = ALU_ORR;
            CMD_EOR: begin
                if (EXT_OPS != 0) dec_ctrl = ALU_EOR;
                else begin dec_valid = 1'b0; dec_nowrite = 1'b1; end
            end
            CMD_CMP: begin
                if (EXT_OPS != 0) begin
                    dec_ctrl    = ALU_SUB;
                    dec_cv      = 1'b1;
                    dec_nowrite = 1'b1;
                end else begin
                    dec_valid   = 1'b0;
                    dec_nowrite = 1'b1;
                end
            end
            default: begin
                dec_valid   = 1'b0;
                dec_nowrite = 1'b1;
            end
        endcase
    end

    assign ALUControl = ALUCTRL_W'((alu_op && dec_valid) ? dec_ctrl : ALU_ADD);
    assign flag_w     = (alu_op && dec_valid) ? {Funct[0], Funct[0] & dec_cv} : 2'b00;
    // NoWrite must survive into ALUWB, where the ALU is no longer decoding cmd.
    assign no_write   = (Op == OP_DP) & dec_nowrite;
    assign pcs        = ((Rd == 4'd15) & reg_w) | branch;
    assign flag_en    = (state == S_EXECR) || (state == S_EXECI);

    arm_cond_logic u_cond (
        .CLK      (CLK),
        .RST      (RST),
        .Cond     (Cond),
        .ALUFlags (ALUFlags),
        .FlagW    (flag_w),
        .flag_en  (flag_en),
        .PCS      (pcs),
        .NextPC   (next_pc),
        .RegW     (reg_w),
        .MemW     (mem_w),
        .NoWrite  (no_write),
        .PCWrite  (PCWrite),
        .RegWrite (RegWrite),
        .MemWrite (MemWrite)
    );

    assign IRWrite = ir_write & ~RST;
    assign ImmSrc  = Op;
    assign RegSrc  = {Op == OP_MEM, Op == OP_BR};
    assign State   = state;

endmodule
